// File: rtl/uib_arb.sv
// Round-robin arbiter that connects N_MASTERS uib masters to N_SLAVES uib slaves through one shared path.
// Defining UIB_ARB_TIMEOUT_EN adds a slave-timeout watchdog that answers with ERR_DATA.
module uib_arb #(
    parameter int              N_MASTERS   = 2,
    parameter int              N_SLAVES    = 4,
    parameter int              XLEN        = 32,
    parameter int              SLAVE_WIDTH = 4,
    parameter int              TIMEOUT     = 255,
    parameter logic [XLEN-1:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [N_MASTERS-1:0]                       master_req,
    input  logic [N_MASTERS-1:0]                       master_wen,
    input  logic [N_MASTERS-1:0][2:0]                  master_mode,
    input  logic [N_MASTERS-1:0][SLAVE_WIDTH-1:0]      master_num,
    input  logic [N_MASTERS-1:0][XLEN-SLAVE_WIDTH-1:0] master_addr,
    input  logic [N_MASTERS-1:0][XLEN-1:0]             master_dat_o,
    output logic [N_MASTERS-1:0][XLEN-1:0]             master_dat_i,
    output logic [N_MASTERS-1:0]                       master_ready,
    output logic [N_SLAVES-1:0]                        slave_req,
    output logic [N_SLAVES-1:0]                        slave_wen,
    output logic [N_SLAVES-1:0][2:0]                   slave_mode,
    output logic [N_SLAVES-1:0][XLEN-SLAVE_WIDTH-1:0]  slave_addr,
    output logic [N_SLAVES-1:0][XLEN-1:0]              slave_dat_i,
    input  logic [N_SLAVES-1:0][XLEN-1:0]              slave_dat_o,
    input  logic [N_SLAVES-1:0]                        slave_ready
);

    localparam int AW = XLEN - SLAVE_WIDTH;
    localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                 state;
    logic [MW-1:0]          rr_ptr;
    logic [MW-1:0]          gnt;
    logic [SLAVE_WIDTH-1:0] gnt_num;
    logic                   gnt_wen;

    logic                   any_req;
    logic                   pick_found;
    logic [MW-1:0]          pick;
    logic                   pick_wen;
    logic [2:0]             pick_mode;
    logic [SLAVE_WIDTH-1:0] pick_num;
    logic [AW-1:0]          pick_addr;
    logic [XLEN-1:0]        pick_data;
    logic                   pick_ok;

    logic                   slave_hit;
    logic [XLEN-1:0]        slave_rdata;
    logic [MW-1:0]          rr_next;

`ifdef UIB_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_expired;
    assign tmo_expired = (tmo_cnt == TW'(TIMEOUT - 1));
`endif

    assign any_req = |master_req;

    // First requester at or above the pointer wins; otherwise wrap to the lowest requester.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            if (!pick_found && master_req[m] && (MW'(m) >= rr_ptr)) begin
                pick_found = 1'b1;
                pick       = MW'(m);
            end
        end
        for (int m = 0; m < N_MASTERS; m++) begin
            if (!pick_found && master_req[m]) begin
                pick_found = 1'b1;
                pick       = MW'(m);
            end
        end
    end

    always_comb begin
        pick_wen  = 1'b0;
        pick_mode = '0;
        pick_num  = '0;
        pick_addr = '0;
        pick_data = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            if (pick == MW'(m)) begin
                pick_wen  = master_wen[m];
                pick_mode = master_mode[m];
                pick_num  = master_num[m];
                pick_addr = master_addr[m];
                pick_data = master_dat_o[m];
            end
        end
    end

    // One extra bit so N_SLAVES == 2**SLAVE_WIDTH cannot wrap to zero.
    assign pick_ok = ({1'b0, pick_num} < (SLAVE_WIDTH + 1)'(N_SLAVES));

    always_comb begin
        slave_hit   = 1'b0;
        slave_rdata = '0;
        for (int s = 0; s < N_SLAVES; s++) begin
            if ((gnt_num == SLAVE_WIDTH'(s)) && slave_ready[s]) begin
                slave_hit   = 1'b1;
                slave_rdata = slave_dat_o[s];
            end
        end
    end

    assign rr_next = (gnt == MW'(N_MASTERS - 1)) ? '0 : gnt + MW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            gnt          <= '0;
            gnt_num      <= '0;
            gnt_wen      <= 1'b0;
            master_ready <= '0;
            master_dat_i <= '0;
            slave_req    <= '0;
            slave_wen    <= '0;
            slave_mode   <= '0;
            slave_addr   <= '0;
            slave_dat_i  <= '0;
`ifdef UIB_ARB_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            master_ready <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt     <= pick;
                        gnt_num <= pick_num;
                        gnt_wen <= pick_wen;
                        if (pick_ok) begin
                            state <= BUSY;
                            for (int s = 0; s < N_SLAVES; s++) begin
                                if (pick_num == SLAVE_WIDTH'(s)) begin
                                    slave_req[s]   <= 1'b1;
                                    slave_wen[s]   <= pick_wen;
                                    slave_mode[s]  <= pick_mode;
                                    slave_addr[s]  <= pick_addr;
                                    slave_dat_i[s] <= pick_data;
                                end
                            end
`ifdef UIB_ARB_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end else begin
                            // Decode error skips the slave side and answers straight away.
                            state <= RESP;
                            for (int m = 0; m < N_MASTERS; m++) begin
                                if (pick == MW'(m)) begin
                                    master_ready[m] <= 1'b1;
                                    master_dat_i[m] <= ERR_DATA;
                                end
                            end
                        end
                    end
                end
                BUSY: begin
                    if (slave_hit) begin
                        state       <= RESP;
                        slave_req   <= '0;
                        slave_wen   <= '0;
                        slave_mode  <= '0;
                        slave_addr  <= '0;
                        slave_dat_i <= '0;
                        for (int m = 0; m < N_MASTERS; m++) begin
                            if (gnt == MW'(m)) begin
                                master_ready[m] <= 1'b1;
                                master_dat_i[m] <= gnt_wen ? '0 : slave_rdata;
                            end
                        end
                    end
`ifdef UIB_ARB_TIMEOUT_EN
                    else if (tmo_expired) begin
                        state       <= RESP;
                        slave_req   <= '0;
                        slave_wen   <= '0;
                        slave_mode  <= '0;
                        slave_addr  <= '0;
                        slave_dat_i <= '0;
                        for (int m = 0; m < N_MASTERS; m++) begin
                            if (gnt == MW'(m)) begin
                                master_ready[m] <= 1'b1;
                                master_dat_i[m] <= ERR_DATA;
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                RESP: begin
                    rr_ptr <= rr_next;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uib_arb.md
Name: uib_arb

Overview:
- Parametrised successor to the fixed single-master uib fabric.
- Arbitrates N_MASTERS uib masters onto a shared path to N_SLAVES uib slaves.
- Round-robin fairness, registered grant, explicit transaction FSM, decode-error response, optional slave-timeout watchdog.
- Sits between cpu/DMA-class masters and mainmem/perf-class slaves in the top level.

Parameters:
- N_MASTERS, 2, number of master ports (≥1)
- N_SLAVES, 4, number of slave ports (≤2^SLAVE_WIDTH)
- XLEN, 32, data/address width
- SLAVE_WIDTH, 4, width of master_num slave select
- TIMEOUT, 255, cycles to wait for slave_ready before error (used only with UIB_ARB_TIMEOUT_EN)
- ERR_DATA, 32'hDEADBEEF, read data returned on decode error/timeout

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- master_req  in  [N_MASTERS]  request, held until master_ready
- master_wen  in  [N_MASTERS]  1 = write
- master_mode  in  [N_MASTERS][3]  access size/mode, passed through
- master_num  in  [N_MASTERS][SLAVE_WIDTH]  target slave index
- master_addr  in  [N_MASTERS][XLEN-SLAVE_WIDTH]  offset within slave
- master_dat_o  in  [N_MASTERS][XLEN]  write data from master
- master_dat_i  out  [N_MASTERS][XLEN]  read data to master
- master_ready  out  [N_MASTERS]  one-cycle completion pulse
- slave_req  out  [N_SLAVES]  request to slave
- slave_wen  out  [N_SLAVES]  write enable
- slave_mode  out  [N_SLAVES][3]  mode
- slave_addr  out  [N_SLAVES][XLEN-SLAVE_WIDTH]  offset
- slave_dat_i  out  [N_SLAVES][XLEN]  write data to slave
- slave_dat_o  in  [N_SLAVES][XLEN]  read data from slave
- slave_ready  in  [N_SLAVES]  slave completion

Behaviour:
- Reset: state IDLE; rr pointer 0; all outputs 0 (master_ready, master_dat_i, slave_req, slave_wen, slave_mode, slave_addr, slave_dat_i).
- Reset mid-transaction aborts it. slave_req drops the next cycle. No master_ready is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any master_req, pick the first requester at or after the rr pointer, wrapping modulo N_MASTERS.
  - Register grant index g and the request fields.
  - If master_num[g] < N_SLAVES, go to BUSY; otherwise go to RESP with error flag set.
- BUSY:
  - slave_req[s]=1 with registered wen/mode/addr/data.
  - All non-selected slave outputs are 0.
  - On slave_ready[s]=1: capture slave_dat_o[s] (reads only; writes capture 0) and go to RESP.
  - slave_req deasserts in RESP.
- RESP:
  - master_ready[g]=1 and master_dat_i[g] = captured data (ERR_DATA on error) for exactly one cycle.
  - Update rr pointer to (g+1) mod N_MASTERS; go to IDLE.
- master_dat_i[g] holds its value until g's next RESP. Other masters' master_dat_i are unaffected.
- Latency: req seen in IDLE cycle 0 → slave_req cycle 1. slave_ready at cycle k → master_ready at cycle k+1.
- Minimum transaction is 3 cycles. There is no back-to-back grant out of RESP (mandatory IDLE cycle).
- Request fields are sampled only at grant. A master dropping req during BUSY does not abort; the pulse is still delivered.
- Simultaneous requests: exactly one grant. Losers keep req high and win in rr order. Starvation bound: N_MASTERS transactions.
- slave_ready on a non-selected slave is ignored.
- master_num is compared at full SLAVE_WIDTH; no truncation.

Optional Feature:
- Macro UIB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on BUSY entry and increments each BUSY cycle.
  - When it reaches TIMEOUT without slave_ready, go to RESP with error (ERR_DATA) and drop slave_req.
  - slave_ready in the same cycle as expiry wins (normal data).
- Undefined: no counter; BUSY waits indefinitely.

Test Plan:
- Single read: M0 req, num=1, addr=0x10, wen=0. S1 ready at cycle 3 with 0x12345678 → slave_req[1] cycles 1-3; master_ready[0] at cycle 4 with master_dat_i[0]=0x12345678.
- Write passthrough: M1 wen=1, mode=3'b010, dat=0xA5A5A5A5 → slave_dat_i[0]=0xA5A5A5A5, slave_wen[0]=1 while slave_req[0]=1; master_dat_i[1]=0.
- Round-robin: M0 and M1 both hold req continuously, slaves ready immediately → grants alternate 0,1,0,1; master_ready pulses every 3 cycles.
- Decode error: num=5 with N_SLAVES=4 → no slave_req; master_ready at cycle 1 with 0xDEADBEEF.
- Timeout (UIB_ARB_TIMEOUT_EN, TIMEOUT=4): slave never ready → slave_req high 4 cycles, then master_ready with 0xDEADBEEF.
- Reset mid-BUSY: rst at cycle 2 of a transaction → cycle 3 all outputs 0, no master_ready; next request is granted to M0.
